riscv_div_ctrl: RTL and testbench
=================================

// Module: riscv_div_ctrl
// PURPOSE
//  Sequencer for the shared combinational unsigned divider in the RV32M execute stage.
//  Accepts DIV/DIVU/REM/REMU requests and takes magnitudes for signed ops.
//  Drives the divider for DIV_LATENCY cycles (multicycle path), then applies sign fix-up.
//  Returns one 32-bit result with the request tag; handles divide-by-zero and pipeline kill.
// PARAMETERS
//  DIV_LATENCY  2   cycles divider inputs are held stable before capture (>=1)
//  TAG_W        5   width of request tag (destination register index)
// PORTS
//  clk            in   1      core clock
//  reset_n        in   1      synchronous reset, active-low
//  kill           in   1      flush: cancel any in-flight/pending op
//  req_valid      in   1      request present
//  req_ready      out  1      controller can accept (IDLE only)
//  req_op         in   2      bit0=unsigned, bit1=remainder (00 DIV,01 DIVU,10 REM,11 REMU)
//  req_a          in   32     dividend
//  req_b          in   32     divisor
//  req_tag        in   TAG_W  returned unchanged with result
//  resp_valid     out  1      result available
//  resp_ready     in   1      consumer takes result
//  resp_data      out  32     quotient or remainder, per op
//  resp_tag       out  TAG_W  tag of this result
//  div_x, div_y   out  32     unsigned operands to divider (registered)
//  div_q, div_r   in   32     divider quotient/remainder (valid after DIV_LATENCY cycles)
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state IDLE, resp_valid=0, resp_data=0, resp_tag=0,
//   div_x=div_y=0, counter=0; req_ready=0 while reset_n low, 1 from first cycle after.
//  FSM IDLE -> CALC -> DONE -> IDLE. req_ready = (state==IDLE) && reset_n.
//  IDLE: on req_valid&&req_ready latch op,tag; sign_a=a[31]&~op[0], sign_b=b[31]&~op[0];
//   div_x=|a|, div_y=|b| (two's-complement magnitude; 0x80000000 stays 0x80000000).
//   b==0 -> DONE directly: DIV/DIVU result 0xFFFFFFFF, REM/REMU result a. Latency 1.
//   else -> CALC, counter=DIV_LATENCY-1.
//  CALC: counter decrements; at 0 capture: q'=(sign_a^sign_b)?-div_q:div_q,
//   r'=sign_a?-div_r:div_r; resp_data=op[1]?r':q'; -> DONE.
//   Accept in cycle N -> resp_valid first high in cycle N+DIV_LATENCY+1.
//  DONE: resp_valid=1, resp_data/resp_tag stable until resp_valid&&resp_ready -> IDLE.
//   No new accept in the handshake cycle (next accept earliest cycle after).
//  Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0 (falls out of fix-up; must hold).
//  kill: highest priority after reset; any state -> IDLE next cycle, resp_valid=0,
//   a request presented with kill is not accepted. Divider outputs ignored.
//  All arithmetic 32-bit modulo 2^32; div_x/div_y do not change during CALC.
// CONFIGURATION
//  RISCV_DIV_RESULT_CACHE_EN defined: one-entry cache {a,b,op[0],q',r',valid}, written at
//   every CALC capture, cleared by reset (not by kill). Request with same a,b,op[0] and
//   valid entry -> DONE with cached q'/r' selected by op[1], latency 1 (DIV+REM pair fusion).
//   Divide-by-zero fast path does not write the cache.
//  Undefined: no cache; every non-zero-divisor op goes through CALC.
// STRUCTURE
//  Package riscv_div_pkg: op encoding localparams (DIV_OP_DIV..DIV_OP_REMU), op bit
//   indices (UNSIGNED_BIT=0, REM_BIT=1), state enum (ST_IDLE,ST_CALC,ST_DONE), DIV_ZERO_Q.
//  Sub-module riscv_div_sign_fix (combinational): {div_q,div_r,sign_a,sign_b} -> {q',r'}.
//  Divider itself instantiated by the parent; this block only drives/samples it.
// TESTING
//  DIVU a=100,b=7, resp_ready=1 -> resp_data=14 at accept+DIV_LATENCY+1, tag echoed.
//  REM a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFF; DIV same -> 0xFFFFFFFD.
//  DIV a=5,b=0 -> 0xFFFFFFFF; REMU a=5,b=0 -> 5; both resp_valid 1 cycle after accept.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  kill asserted in CALC -> resp_valid stays 0, req_ready=1 next cycle; resp_ready=0 in DONE
//   for 3 cycles -> resp_data/tag stable, req_ready=0 throughout.
//  With cache EN: DIV 100/7 then REM 100/7 -> 14 then 2, second with latency 1;
//   reset_n=0 mid-CALC -> all outputs reset values next cycle, cache invalid.

Source files
------------

// File: rtl/riscv_div_pkg.sv
// Shared definitions for the RV32M divide sequencer: op encoding, FSM states, cache entry.
// The optional result cache is enabled by defining RISCV_DIV_RESULT_CACHE_EN.
package riscv_div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int UNSIGNED_BIT = 0;
  localparam int REM_BIT      = 1;

  // Quotient returned for a zero divisor (all ones, as RV32M requires).
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic        valid;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } div_cache_t;

  // Two's-complement negate when neg is set; 0x80000000 maps onto itself.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/riscv_div_sign_fix.sv
// Combinational sign restoration of the unsigned divider outputs.
// Quotient is negated when operand signs differ; remainder follows the dividend sign.
module riscv_div_sign_fix
  import riscv_div_pkg::*;
(
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        sign_a,
  input  logic        sign_b,
  output logic [31:0] q_fix,
  output logic [31:0] r_fix
);

  logic [1:0][31:0] lane_in;
  logic [1:0][31:0] lane_out;
  logic [1:0]       lane_neg;

  // Lane 0 carries the quotient, lane 1 the remainder.
  assign lane_in  = {div_r, div_q};
  assign lane_neg = {sign_a, sign_a ^ sign_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_out[gi] = cond_neg(lane_in[gi], lane_neg[gi]);
    end
  endgenerate

  assign q_fix = lane_out[0];
  assign r_fix = lane_out[1];

endmodule

// File: rtl/riscv_div_ctrl.sv
// Sequencer for the shared multicycle unsigned divider (DIV/DIVU/REM/REMU).
// Define RISCV_DIV_RESULT_CACHE_EN to add a one-entry result cache for DIV/REM pairs.
module riscv_div_ctrl
  import riscv_div_pkg::*;
#(
  parameter int DIV_LATENCY = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             kill,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_r
);

  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       op_reg;
  logic             sign_a_reg, sign_b_reg;
  logic [31:0]      div_x_reg, div_y_reg;
  logic [31:0]      resp_data_reg;
  logic [TAG_W-1:0] resp_tag_reg;

  logic        accept, capture, b_zero, cache_hit;
  logic        req_sign_a, req_sign_b;
  logic [31:0] q_fix, r_fix, hit_data;

  assign accept     = req_valid && (state_reg == ST_IDLE) && reset_n && !kill;
  assign capture    = (state_reg == ST_CALC) && (cnt_reg == '0);
  assign b_zero     = (req_b == 32'd0);
  assign req_sign_a = req_a[31] & ~req_op[UNSIGNED_BIT];
  assign req_sign_b = req_b[31] & ~req_op[UNSIGNED_BIT];

  riscv_div_sign_fix u_sign_fix (
    .div_q  (div_q),
    .div_r  (div_r),
    .sign_a (sign_a_reg),
    .sign_b (sign_b_reg),
    .q_fix  (q_fix),
    .r_fix  (r_fix)
  );

`ifdef RISCV_DIV_RESULT_CACHE_EN
  div_cache_t  cache_reg;
  logic [31:0] op_a_reg, op_b_reg;

  assign cache_hit = cache_reg.valid && (cache_reg.a == req_a) && (cache_reg.b == req_b) &&
                     (cache_reg.uns == req_op[UNSIGNED_BIT]);
  assign hit_data  = req_op[REM_BIT] ? cache_reg.r : cache_reg.q;

  // Cache survives kill on purpose: a flushed op never reaches capture, so the entry stays coherent.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cache_reg <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
    end else if (!kill) begin
      if (accept) begin
        op_a_reg <= req_a;
        op_b_reg <= req_b;
      end
      if (capture) begin
        cache_reg <= '{valid: 1'b1, uns: op_reg[UNSIGNED_BIT], a: op_a_reg, b: op_b_reg,
                       q: q_fix, r: r_fix};
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (accept) state_next = (b_zero || cache_hit) ? ST_DONE : ST_CALC;
      ST_CALC: if (capture) state_next = ST_DONE;
      ST_DONE: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (kill) state_next = ST_IDLE;
  end

  // Divider operands are only loaded on accept, so they hold through the whole multicycle path.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      op_reg        <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      div_x_reg     <= '0;
      div_y_reg     <= '0;
      resp_data_reg <= '0;
      resp_tag_reg  <= '0;
    end else if (!kill) begin
      if (accept) begin
        op_reg       <= req_op;
        resp_tag_reg <= req_tag;
        sign_a_reg   <= req_sign_a;
        sign_b_reg   <= req_sign_b;
        div_x_reg    <= cond_neg(req_a, req_sign_a);
        div_y_reg    <= cond_neg(req_b, req_sign_b);
        cnt_reg      <= CNT_LOAD;
        if (b_zero) begin
          resp_data_reg <= req_op[REM_BIT] ? req_a : DIV_ZERO_Q;
        end else if (cache_hit) begin
          resp_data_reg <= hit_data;
        end
      end
      if (state_reg == ST_CALC) begin
        if (capture) begin
          resp_data_reg <= op_reg[REM_BIT] ? r_fix : q_fix;
        end else begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    req_ready  = (state_reg == ST_IDLE) && reset_n;
    resp_valid = (state_reg == ST_DONE);
    resp_data  = resp_data_reg;
    resp_tag   = resp_tag_reg;
    div_x      = div_x_reg;
    div_y      = div_y_reg;
  end

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Randomized self-checking bench for riscv_div_ctrl against a signed-arithmetic reference model.
// Cache expectations follow RISCV_DIV_RESULT_CACHE_EN when it is defined for the build.
module tb_riscv_div_ctrl;

  localparam int L  = 2;
  localparam int TW = 5;
`ifdef RISCV_DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          kill = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [31:0]   req_a = '0;
  logic [31:0]   req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_data;
  logic [TW-1:0] resp_tag;
  logic [31:0]   div_x, div_y, div_q, div_r;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference cache state: last operands that completed a full divide.
  bit          m_cache_valid = 1'b0;
  logic [31:0] m_ca = '0, m_cb = '0;
  logic        m_cu = 1'b0;

  always #5 clk = ~clk;

  riscv_div_ctrl #(.DIV_LATENCY(L), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .kill       (kill),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .div_x      (div_x),
    .div_y      (div_y),
    .div_q      (div_q),
    .div_r      (div_r)
  );

  // Divider model: answers only once its inputs have been stable for L cycles, garbage before.
  logic [31:0] prev_x = '0, prev_y = '0;
  int          stable_cnt = 0;
  int          cur_stable;
  always_comb cur_stable = (div_x == prev_x && div_y == prev_y) ? stable_cnt + 1 : 1;
  always_ff @(posedge clk) begin
    prev_x     <= div_x;
    prev_y     <= div_y;
    stable_cnt <= (cur_stable > 1000) ? 1000 : cur_stable;
  end
  assign div_q = (cur_stable >= L && div_y != 0) ? div_x / div_y : 32'hDEAD_BEEF;
  assign div_r = (cur_stable >= L && div_y != 0) ? div_x % div_y : 32'hDEAD_BEEF;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] v, input logic uns);
    return (!uns && v[31]) ? 32'd0 - v : v;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int          cyc, exp_lat;
    logic [31:0] exp_d;
    logic [4:0]  tag;
    bit          hit;
    tag     = 5'($urandom_range(0, 31));
    hit     = CACHE_EN && m_cache_valid && b != 0 && m_ca == a && m_cb == b && m_cu == op[0];
    exp_lat = (b == 0 || hit) ? 1 : L + 1;
    exp_d   = ref_result(op, a, b);
    @(negedge clk);
    check_value("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom);
    cyc = 1;
    if (exp_lat > 1) begin
      check_value("div_x_mag", 64'(div_x), 64'(ref_mag(a, op[0])));
      check_value("div_y_mag", 64'(div_y), 64'(ref_mag(b, op[0])));
    end
    while (!resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_value("latency", 64'(cyc), 64'(exp_lat));
    check_value("resp_valid", 64'(resp_valid), 64'd1);
    check_value("resp_data", 64'(resp_data), 64'(exp_d));
    check_value("resp_tag", 64'(resp_tag), 64'(tag));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_value("hold_valid", 64'(resp_valid), 64'd1);
      check_value("hold_data", 64'(resp_data), 64'(exp_d));
      check_value("hold_tag", 64'(resp_tag), 64'(tag));
      check_value("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_value("post_hs_valid", 64'(resp_valid), 64'd0);
    check_value("post_hs_ready", 64'(req_ready), 64'd1);
    if (exp_lat == L + 1) begin
      m_cache_valid = 1'b1; m_ca = a; m_cb = b; m_cu = op[0];
    end
    $display("txn op=%0d a=%08h b=%08h tag=%0d data=%08h exp=%08h lat=%0d hold=%0d",
             op, a, b, tag, resp_data, exp_d, cyc, hold);
  endtask

  // Starts a full-latency op and leaves the DUT in its first CALC cycle (at a negedge).
  task automatic start_calc(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = a; req_b = b; req_tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_req_ready", 64'(req_ready), 64'd0);
    check_value("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_value("rst_resp_data", 64'(resp_data), 64'd0);
    check_value("rst_resp_tag", 64'(resp_tag), 64'd0);
    check_value("rst_div_x", 64'(div_x), 64'd0);
    check_value("rst_div_y", 64'(div_y), 64'd0);
    reset_n = 1'b1;
    #1;
    check_value("rel_req_ready", 64'(req_ready), 64'd1);

    run_op(2'b01, 32'd100, 32'd7, 0);
    run_op(2'b00, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(2'b00, 32'd5, 32'd0, 0);
    run_op(2'b11, 32'd5, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b01, 32'hFFFF_FFF0, 32'd3, 3);

    // Kill while idle with a request present: nothing may be accepted.
    @(negedge clk);
    kill = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_a = 32'd50; req_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0; req_valid = 1'b0;
    check_value("kill_idle_ready", 64'(req_ready), 64'd1);
    repeat (L + 1) @(negedge clk);
    check_value("kill_idle_valid", 64'(resp_valid), 64'd0);

    // Kill during CALC.
    start_calc(32'd77, 32'd5);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    check_value("kill_calc_ready", 64'(req_ready), 64'd1);
    check_value("kill_calc_valid", 64'(resp_valid), 64'd0);
    repeat (L + 1) @(negedge clk);
    check_value("kill_calc_late", 64'(resp_valid), 64'd0);

    // Kill while DONE and unacknowledged.
    start_calc(32'd1000, 32'd10);
    repeat (L) @(negedge clk);
    check_value("kill_done_pre", 64'(resp_valid), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    check_value("kill_done_valid", 64'(resp_valid), 64'd0);
    check_value("kill_done_ready", 64'(req_ready), 64'd1);
    m_cache_valid = 1'b1; m_ca = 32'd1000; m_cb = 32'd10; m_cu = 1'b0;

    // Reset mid-CALC after a cacheable DIV: outputs cleared and cache forgotten.
    run_op(2'b00, 32'd100, 32'd7, 0);
    start_calc(32'd100, 32'd8);
    reset_n = 1'b0;
    #1;
    check_value("rst_mid_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_value("rst_mid_valid", 64'(resp_valid), 64'd0);
    check_value("rst_mid_data", 64'(resp_data), 64'd0);
    check_value("rst_mid_tag", 64'(resp_tag), 64'd0);
    check_value("rst_mid_div_x", 64'(div_x), 64'd0);
    check_value("rst_mid_div_y", 64'(div_y), 64'd0);
    reset_n = 1'b1;
    m_cache_valid = 1'b0;
    run_op(2'b10, 32'd100, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      if (i == 0 || $urandom_range(0, 9) >= 3) begin
        ra = pick_operand();
        rb = pick_operand();
      end
      run_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
